// File: rtl/izh_neuron_array.sv
// izh_neuron_array
// An array of Izhikevich-lite neurons that share one update datapath.
// Each tick, a small FSM visits every neuron once and updates its membrane (v)
// and recovery (u) state. It then publishes one spike vector for the whole sweep.
// Each neuron has its own {a,b,c,d} parameters and refractory counter.
// The membrane of one selected neuron can be read back for monitoring.

module izh_neuron_array #(
   parameter int N_NEURONS     = 4,
   parameter int V_WIDTH       = 12,
   parameter int SCALE_SHIFT   = 4,
   parameter int STIM_WIDTH    = 8,
   parameter int PARAM_WIDTH   = 6,
   parameter int DT_SHIFT      = 2,
   parameter int REFRACT_TICKS = 2,
   localparam int ADDR_W       = $clog2(N_NEURONS)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            tick,
   input  logic [N_NEURONS*STIM_WIDTH-1:0] stim_in,
   input  logic [N_NEURONS-1:0]            neuron_en,
   input  logic                            param_we,
   input  logic [ADDR_W-1:0]               param_addr,
   input  logic [4*PARAM_WIDTH-1:0]        param_data,
   input  logic [ADDR_W-1:0]               mem_sel,
   output logic                            busy,
   output logic                            spike_valid,
   output logic [N_NEURONS-1:0]            spike_vec,
   output logic [7:0]                      membrane_out,
   output logic                            tick_overrun
);

   // Internal arithmetic is wide enough for 5*V*V with no overflow.
   localparam int IW = 2*V_WIDTH + 8;
   localparam int RW = (REFRACT_TICKS > 0) ? $clog2(REFRACT_TICKS + 1) : 1;

   localparam logic signed [IW-1:0] V_REST_I   = IW'(-70 * (2**SCALE_SHIFT));
   localparam logic signed [IW-1:0] V_THRESH_I = IW'(30 * (2**SCALE_SHIFT));
   localparam logic signed [IW-1:0] V_MAX_I    = IW'((2**(V_WIDTH-1)) - 1);
   localparam logic signed [IW-1:0] V_MIN_I    = IW'(-(2**(V_WIDTH-1)));
   localparam logic signed [IW-1:0] FIVE       = IW'(5);
   localparam logic signed [IW-1:0] C140       = IW'(140 * (2**SCALE_SHIFT));
   localparam logic signed [IW-1:0] MEM_MAX    = IW'(254);
   localparam logic signed [IW-1:0] ZERO_I     = '0;

   localparam logic signed [V_WIDTH-1:0] V_REST_V = V_WIDTH'(-70 * (2**SCALE_SHIFT));

   localparam logic [PARAM_WIDTH-1:0] A_DEF = PARAM_WIDTH'(20);
   localparam logic [PARAM_WIDTH-1:0] B_DEF = PARAM_WIDTH'(13);
   localparam logic [PARAM_WIDTH-1:0] C_DEF = PARAM_WIDTH'(5);
   localparam logic [PARAM_WIDTH-1:0] D_DEF = PARAM_WIDTH'(8);

   localparam logic [RW-1:0]     REF_LOAD = RW'(REFRACT_TICKS);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURONS - 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SWEEP = 1'b1;

   logic [0:0]                      state;
   logic [ADDR_W-1:0]               idx;
   logic [N_NEURONS*STIM_WIDTH-1:0] stim_lat;
   logic [N_NEURONS-1:0]            en_lat;
   logic [N_NEURONS-1:0]            spike_acc;
   logic [N_NEURONS-1:0]            spike_acc_nxt;

   logic signed [V_WIDTH-1:0] v_mem   [N_NEURONS];
   logic signed [V_WIDTH-1:0] u_mem   [N_NEURONS];
   logic [RW-1:0]             ref_mem [N_NEURONS];

   logic [PARAM_WIDTH-1:0] prm_a [N_NEURONS];
   logic [PARAM_WIDTH-1:0] prm_b [N_NEURONS];
   logic [PARAM_WIDTH-1:0] prm_c [N_NEURONS];
   logic [PARAM_WIDTH-1:0] prm_d [N_NEURONS];

   logic signed [IW-1:0] cur_v, cur_u, stim_ext;
   logic signed [IW-1:0] pa, pb, pc, pd;
   logic signed [IW-1:0] v_sq, dv, bv, du;
   logic signed [IW-1:0] v_int, u_int, v_spk, u_spk;
   logic [STIM_WIDTH-1:0] stim_sel;

   logic signed [V_WIDTH-1:0] nxt_v, nxt_u;
   logic [RW-1:0]             nxt_ref;
   logic                      spike_now;

   logic signed [IW-1:0] sel_v, mem_diff;
   logic [7:0]           mem_next;

   function automatic logic signed [IW-1:0] sext(input logic signed [V_WIDTH-1:0] x);
      return {{(IW-V_WIDTH){x[V_WIDTH-1]}}, x};
   endfunction

   function automatic logic signed [IW-1:0] zext_p(input logic [PARAM_WIDTH-1:0] x);
      return {{(IW-PARAM_WIDTH){1'b0}}, x};
   endfunction

   // Clamp a wide result to the state range so v and u never wrap around.
   function automatic logic signed [V_WIDTH-1:0] sat_v(input logic signed [IW-1:0] x);
      logic signed [V_WIDTH-1:0] r;
      if (x > V_MAX_I)
         r = V_MAX_I[V_WIDTH-1:0];
      else if (x < V_MIN_I)
         r = V_MIN_I[V_WIDTH-1:0];
      else
         r = x[V_WIDTH-1:0];
      return r;
   endfunction

   // Shared datapath: compute the candidate next state of the neuron at idx.
   always_comb begin
      cur_v    = sext(v_mem[idx]);
      cur_u    = sext(u_mem[idx]);
      stim_sel = stim_lat[idx*STIM_WIDTH +: STIM_WIDTH];
      stim_ext = {{(IW-STIM_WIDTH){1'b0}}, stim_sel};
      pa       = zext_p(prm_a[idx]);
      pb       = zext_p(prm_b[idx]);
      pc       = zext_p(prm_c[idx]);
      pd       = zext_p(prm_d[idx]);

      v_sq  = (FIVE * cur_v * cur_v) >>> (7 + SCALE_SHIFT);
      dv    = v_sq + (FIVE * cur_v) + C140 - cur_u + (stim_ext <<< SCALE_SHIFT);
      bv    = (pb * cur_v) >>> 6;
      du    = (pa * (bv - cur_u)) >>> 10;
      v_int = cur_v + (dv >>> DT_SHIFT);
      u_int = cur_u + (du >>> DT_SHIFT);
      v_spk = V_REST_I + (pc <<< SCALE_SHIFT);
      u_spk = cur_u + (pd <<< SCALE_SHIFT);
   end

   // Choose what this neuron does this tick: frozen, refractory, spike or integrate.
   always_comb begin
      nxt_v     = v_mem[idx];
      nxt_u     = u_mem[idx];
      nxt_ref   = ref_mem[idx];
      spike_now = 1'b0;
      if (en_lat[idx]) begin
         if (ref_mem[idx] != '0) begin
            nxt_ref = ref_mem[idx] - 1'b1;
         end else if (cur_v >= V_THRESH_I) begin
            nxt_v     = sat_v(v_spk);
            nxt_u     = sat_v(u_spk);
            nxt_ref   = REF_LOAD;
            spike_now = 1'b1;
         end else begin
            nxt_v = sat_v(v_int);
            nxt_u = sat_v(u_int);
         end
      end
      spike_acc_nxt      = spike_acc;
      spike_acc_nxt[idx] = spike_now;
   end

   // Sweep sequencer with neuron state write-back and spike publication.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         idx          <= '0;
         stim_lat     <= '0;
         en_lat       <= '0;
         spike_acc    <= '0;
         spike_vec    <= '0;
         spike_valid  <= 1'b0;
         busy         <= 1'b0;
         tick_overrun <= 1'b0;
         for (int i = 0; i < N_NEURONS; i++) begin
            v_mem[i]   <= V_REST_V;
            u_mem[i]   <= '0;
            ref_mem[i] <= '0;
         end
      end else begin
         spike_valid  <= 1'b0;
         tick_overrun <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tick) begin
                  stim_lat  <= stim_in;
                  en_lat    <= neuron_en;
                  idx       <= '0;
                  spike_acc <= '0;
                  busy      <= 1'b1;
                  state     <= ST_SWEEP;
               end
            end
            ST_SWEEP: begin
               if (tick)
                  tick_overrun <= 1'b1;
               v_mem[idx]   <= nxt_v;
               u_mem[idx]   <= nxt_u;
               ref_mem[idx] <= nxt_ref;
               spike_acc    <= spike_acc_nxt;
               if (idx == LAST_IDX) begin
                  spike_vec   <= spike_acc_nxt;
                  spike_valid <= 1'b1;
                  busy        <= 1'b0;
                  state       <= ST_IDLE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Parameter table writes; a neuron updating on the same edge still sees the old values.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            prm_a[i] <= A_DEF;
            prm_b[i] <= B_DEF;
            prm_c[i] <= C_DEF;
            prm_d[i] <= D_DEF;
         end
      end else if (param_we && (int'(param_addr) < N_NEURONS)) begin
         prm_a[param_addr] <= param_data[4*PARAM_WIDTH-1 -: PARAM_WIDTH];
         prm_b[param_addr] <= param_data[3*PARAM_WIDTH-1 -: PARAM_WIDTH];
         prm_c[param_addr] <= param_data[2*PARAM_WIDTH-1 -: PARAM_WIDTH];
         prm_d[param_addr] <= param_data[PARAM_WIDTH-1 -: PARAM_WIDTH];
      end
   end

   // Map the selected membrane to a byte: 0 at rest, saturating at 254, FF when above threshold.
   always_comb begin
      sel_v    = (int'(mem_sel) < N_NEURONS) ? sext(v_mem[mem_sel]) : V_REST_I;
      mem_diff = (sel_v - V_REST_I) >>> (SCALE_SHIFT - 1);
      if (sel_v >= V_THRESH_I)
         mem_next = 8'hFF;
      else if (mem_diff < ZERO_I)
         mem_next = 8'h00;
      else if (mem_diff > MEM_MAX)
         mem_next = 8'd254;
      else
         mem_next = mem_diff[7:0];
   end

   // Register the readout so it has one cycle of latency from mem_sel.
   always_ff @(posedge clk) begin
      if (reset)
         membrane_out <= 8'h00;
      else
         membrane_out <= mem_next;
   end

endmodule

// File: tb/tb_izh_neuron_array.sv
// tb_izh_neuron_array
// Self-checking bench for izh_neuron_array. A behavioural model is stepped on
// every tick, and the spike vector it predicts goes into a queue. That entry is
// popped and compared when the DUT raises spike_valid. The model also supplies
// the expected membrane readouts.

module tb_izh_neuron_array;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tick = 1'b0;
   logic [31:0] stim_in = '0;
   logic [3:0]  neuron_en = '0;
   logic        param_we = 1'b0;
   logic [1:0]  param_addr = '0;
   logic [23:0] param_data = '0;
   logic [1:0]  mem_sel = '0;
   logic        busy, spike_valid, tick_overrun;
   logic [3:0]  spike_vec;
   logic [7:0]  membrane_out;

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [3:0] exp_q [$];

   longint mv [N];
   longint mu [N];
   int     mref [N];
   int     ma [N];
   int     mb [N];
   int     mc [N];
   int     md [N];

   izh_neuron_array dut (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .stim_in      (stim_in),
      .neuron_en    (neuron_en),
      .param_we     (param_we),
      .param_addr   (param_addr),
      .param_data   (param_data),
      .mem_sel      (mem_sel),
      .busy         (busy),
      .spike_valid  (spike_valid),
      .spike_vec    (spike_vec),
      .membrane_out (membrane_out),
      .tick_overrun (tick_overrun)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Watchdog so the run can never hang
   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint satv(input longint x);
      if (x > 2047) return 2047;
      if (x < -2048) return -2048;
      return x;
   endfunction

   function automatic logic [7:0] memExp(input longint v);
      longint d;
      if (v >= 480) return 8'hFF;
      d = (v + 1120) >>> 3;
      if (d < 0) return 8'h00;
      if (d > 254) return 8'd254;
      return 8'(d);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < N; i++) begin
         mv[i] = -1120; mu[i] = 0; mref[i] = 0;
         ma[i] = 20; mb[i] = 13; mc[i] = 5; md[i] = 8;
      end
      exp_q.delete();
   endtask

   task automatic modelTick(input logic [31:0] stim, input logic [3:0] en, output logic [3:0] spk);
      longint vv, uu, dv, du;
      int s;
      spk = 4'b0000;
      for (int i = 0; i < N; i++) begin
         s  = int'(stim[i*8 +: 8]);
         vv = mv[i];
         uu = mu[i];
         if (!en[i]) begin
         end else if (mref[i] > 0) begin
            mref[i] = mref[i] - 1;
         end else if (vv >= 480) begin
            mv[i]   = satv(-1120 + mc[i] * 16);
            mu[i]   = satv(uu + md[i] * 16);
            mref[i] = 2;
            spk[i]  = 1'b1;
         end else begin
            dv    = ((5 * vv * vv) >>> 11) + 5 * vv + 2240 - uu + s * 16;
            du    = (ma[i] * (((mb[i] * vv) >>> 6) - uu)) >>> 10;
            mv[i] = satv(vv + (dv >>> 2));
            mu[i] = satv(uu + (du >>> 2));
         end
      end
   endtask

   task automatic resetDut();
      @(negedge clk);
      reset = 1'b1;
      tick  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      modelReset();
   endtask

   task automatic writeParam(input int addr, input int a, input int b, input int c, input int d);
      @(negedge clk);
      param_we   = 1'b1;
      param_addr = 2'(addr);
      param_data = {6'(a), 6'(b), 6'(c), 6'(d)};
      @(negedge clk);
      param_we = 1'b0;
      ma[addr] = a; mb[addr] = b; mc[addr] = c; md[addr] = d;
   endtask

   task automatic readMem(input int sel, input string tag, output logic [7:0] val);
      @(negedge clk);
      mem_sel = 2'(sel);
      @(negedge clk);
      val = membrane_out;
      checkOutput(tag, val, memExp(mv[sel]));
   endtask

   // One tick: push the model's prediction, then wait (bounded) for the sweep result
   task automatic applyStimulus(input logic [31:0] stim, input logic [3:0] en,
                                input bit inject_overrun, output logic [3:0] got);
      logic [3:0] exp;
      int lat, busy_cnt, ov_cnt;
      @(negedge clk);
      stim_in   = stim;
      neuron_en = en;
      tick      = 1'b1;
      modelTick(stim, en, exp);
      exp_q.push_back(exp);
      @(negedge clk);
      tick     = 1'b0;
      lat      = 0;
      busy_cnt = 0;
      ov_cnt   = 0;
      while (!spike_valid && lat < 20) begin
         if (busy) busy_cnt++;
         if (tick_overrun) ov_cnt++;
         tick = (inject_overrun && lat == 1) ? 1'b1 : 1'b0;
         @(negedge clk);
         lat++;
      end
      tick = 1'b0;
      got  = spike_vec;
      if (!spike_valid) begin
         checkOutput("sweep_timeout", 32'd0, 32'd1);
         void'(exp_q.pop_front());
      end else begin
         checkOutput("spike_vec", spike_vec, exp_q.pop_front());
         checkOutput("latency", lat, N);
         checkOutput("busy_cycles", busy_cnt, N);
         checkOutput("busy_at_valid", busy, 0);
      end
      @(negedge clk);
      if (tick_overrun) ov_cnt++;
      checkOutput("valid_one_cycle", spike_valid, 0);
      checkOutput("spike_vec_held", spike_vec, got);
      checkOutput("overrun_count", ov_cnt, inject_overrun ? 1 : 0);
   endtask

   initial begin
      logic [3:0] got;
      logic [7:0] mval;
      int         any_spk, saw, cnt;

      modelReset();

      // T1 reset state
      resetDut();
      checkOutput("t1_busy", busy, 0);
      checkOutput("t1_spike_vec", spike_vec, 0);
      checkOutput("t1_spike_valid", spike_valid, 0);
      checkOutput("t1_overrun", tick_overrun, 0);
      for (int i = 0; i < N; i++) begin
         readMem(i, "t1_mem", mval);
         checkOutput("t1_mem_zero", mval, 0);
      end

      // T2 quiet network
      any_spk = 0;
      for (int k = 0; k < 200; k++) begin
         applyStimulus(32'h0, 4'hF, 1'b0, got);
         if (got != 4'b0) any_spk = 1;
      end
      checkOutput("t2_no_spikes", any_spk, 0);
      for (int i = 0; i < N; i++) begin
         readMem(i, "t2_mem", mval);
         checkOutput("t2_below_thresh", (mval != 8'hFF), 1);
      end

      // T3 drive neuron 0 hard
      resetDut();
      saw = 0;
      for (int k = 0; k < 10 && saw == 0; k++) begin
         applyStimulus(32'h0000_00FF, 4'hF, 1'b0, got);
         if (got[0]) begin
            saw = 1;
            checkOutput("t3_vec", got, 4'b0001);
         end
      end
      checkOutput("t3_spike_within_10", saw, 1);
      readMem(0, "t3_mem_model", mval);
      checkOutput("t3_mem_after_spike", mval, 10);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(32'h0000_00FF, 4'hF, 1'b0, got);
         checkOutput("t3_refract_silent", got[0], 0);
         readMem(0, "t3_refract_mem_model", mval);
         checkOutput("t3_refract_mem", mval, 10);
      end
      applyStimulus(32'h0000_00FF, 4'hF, 1'b0, got);
      readMem(0, "t3_resume_model", mval);
      checkOutput("t3_resume", (mval != 8'd10), 1);

      // T4 timing and overrun
      resetDut();
      applyStimulus(32'h0, 4'hF, 1'b1, got);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (spike_valid || busy) cnt++;
      end
      checkOutput("t4_single_sweep", cnt, 0);

      // T5 parameters and enable mask (every 2-bit address is in range for N=4)
      resetDut();
      writeParam(1, 0, 13, 5, 8);
      writeParam(3, 20, 13, 20, 8);
      any_spk = 0;
      saw     = 0;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(32'hFFFF_FFFF, 4'b1011, 1'b0, got);
         if (got[2]) any_spk = 1;
         if (got[3]) saw = 1;
         if (k % 3 == 2) begin
            for (int i = 0; i < N; i++) readMem(i, "t5_mem", mval);
         end
      end
      checkOutput("t5_n2_never", any_spk, 0);
      checkOutput("t5_n3_spiked", saw, 1);
      readMem(2, "t5_n2_frozen_model", mval);
      checkOutput("t5_n2_frozen", mval, 0);

      // T6 reset in the middle of a sweep
      resetDut();
      for (int k = 0; k < 3; k++) applyStimulus(32'h6464_6464, 4'hF, 1'b0, got);
      @(negedge clk);
      stim_in = 32'h6464_6464;
      tick    = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      modelReset();
      checkOutput("t6_busy", busy, 0);
      checkOutput("t6_spike_vec", spike_vec, 0);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (spike_valid) cnt++;
      end
      checkOutput("t6_no_valid", cnt, 0);
      for (int i = 0; i < N; i++) readMem(i, "t6_mem_rest", mval);
      applyStimulus(32'h6464_6464, 4'hF, 1'b0, got);
      for (int i = 0; i < N; i++) readMem(i, "t6_mem_after", mval);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
